// File: rtl/colorled_pkg.sv
// Shared constants, state encodings and tick-divider helpers for the
// colour-LED pattern controller.
package colorled_pkg;

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_BURST = 2'd3;

  typedef enum logic [1:0] {
    S_OFF,
    S_ON_PH,
    S_OFF_PH,
    S_TOG
  } state_e;

  // Sub-steps of the three-cycle toggle primitive driven from S_TOG.
  typedef enum logic [1:0] {
    TOG_ARM,
    TOG_FALL,
    TOG_DONE
  } tog_step_e;

  localparam int unsigned TICK_DIV_MIN = 4;

  function automatic int unsigned calc_tick_div(input int unsigned clk_hz,
                                                input int unsigned tick_hz);
    return clk_hz / tick_hz;
  endfunction

  function automatic bit tick_div_ok(input int unsigned div);
    return div >= TICK_DIV_MIN;
  endfunction

endpackage

// File: rtl/colorled_tick_gen.sv
// Free-running prescaler: one-cycle o_tick pulse every DIV clocks.
module colorled_tick_gen
  import colorled_pkg::*;
#(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic aresetn,
  output logic o_tick
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  if (!tick_div_ok(DIV)) begin : g_div_check
    $error("colorled_tick_gen: DIV must be at least %0d", TICK_DIV_MIN);
  end

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
  assign o_tick = (cnt_q == LAST);

  // NOTE: registers are updated with non-blocking assignments so every
  // flop samples the pre-edge value of its inputs, independent of order.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/colorled_blink_ctrl.sv
// Pattern controller for the colour-LED toggle stage: keeps a shadow of the
// LED state and issues enable/sync toggle primitives for OFF/ON/BLINK/BURST.
module colorled_blink_ctrl
  import colorled_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 1000,
  parameter int          CNT_W   = 16
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic [1:0]       i_mode,
  input  logic [CNT_W-1:0] i_on_ms,
  input  logic [CNT_W-1:0] i_off_ms,
  input  logic [3:0]       i_burst_n,
  input  logic             i_start,
  output logic             o_enable_colorled,
  output logic             o_syncing_colLED,
  output logic             o_led_on,
  output logic             o_busy
);

  localparam int unsigned TICK_DIV = calc_tick_div(CLK_HZ, TICK_HZ);
  localparam logic [CNT_W-1:0] PER_ONE = CNT_W'(1);

  logic tick;

  colorled_tick_gen #(
    .DIV(TICK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .aresetn(aresetn),
    .o_tick (tick)
  );

  state_e           state_q;
  state_e           tgt_q;
  tog_step_e        step_q;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] per_q;
  logic [3:0]       burst_q;
  logic             en_q;
  logic             sync_q;
  logic             led_q;
  logic             busy_q;

  logic [CNT_W-1:0] on_per;
  logic [CNT_W-1:0] off_per;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] cnt_first;
  logic             mode_chg;
  logic             burst_mode;
  logic             run_pattern;
  logic             want_lit;
  logic             start_ok;
  logic             phase_done;

  assign on_per     = (i_on_ms  == '0) ? PER_ONE : i_on_ms;
  assign off_per    = (i_off_ms == '0) ? PER_ONE : i_off_ms;
  assign cnt_inc    = cnt_q + CNT_W'(tick);
  // A tick landing on a phase-entry edge already belongs to the new phase.
  assign cnt_first  = CNT_W'(tick);
  assign phase_done = (cnt_q >= per_q);

  assign mode_chg    = (i_mode != mode_q);
  assign burst_mode  = (i_mode == MODE_BURST);
  assign run_pattern = (i_mode == MODE_BLINK) || (burst_mode && busy_q && !mode_chg);
  assign want_lit    = (i_mode == MODE_ON);
  assign start_ok    = burst_mode && !mode_chg && !busy_q && i_start && (i_burst_n != 4'd0);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_OFF;
      tgt_q   <= S_OFF;
      step_q  <= TOG_ARM;
      mode_q  <= MODE_OFF;
      cnt_q   <= '0;
      per_q   <= PER_ONE;
      burst_q <= 4'd0;
      en_q    <= 1'b0;
      sync_q  <= 1'b0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else if (state_q == S_TOG) begin
      // Mode changes wait here until the primitive has fully completed.
      cnt_q <= cnt_inc;
      unique case (step_q)
        TOG_ARM: begin
          en_q   <= 1'b1;
          sync_q <= 1'b1;
          step_q <= TOG_FALL;
        end
        TOG_FALL: begin
          en_q   <= 1'b0;
          led_q  <= ~led_q;
          step_q <= TOG_DONE;
        end
        default: begin
          sync_q  <= 1'b0;
          step_q  <= TOG_ARM;
          state_q <= tgt_q;
        end
      endcase
    end else begin
      mode_q <= i_mode;
      if (mode_chg) begin
        busy_q  <= 1'b0;
        burst_q <= 4'd0;
      end

      if (run_pattern) begin
        if (mode_chg || (state_q == S_OFF)) begin
          per_q <= on_per;
          cnt_q <= cnt_first;
          if (led_q) begin
            state_q <= S_ON_PH;
          end else begin
            tgt_q   <= S_ON_PH;
            state_q <= S_TOG;
          end
        end else if (!phase_done) begin
          cnt_q <= cnt_inc;
        end else if (state_q == S_ON_PH) begin
          per_q   <= off_per;
          cnt_q   <= cnt_first;
          tgt_q   <= S_OFF_PH;
          state_q <= S_TOG;
        end else if (burst_mode && (burst_q <= 4'd1)) begin
          state_q <= S_OFF;
          busy_q  <= 1'b0;
          burst_q <= 4'd0;
          cnt_q   <= '0;
        end else begin
          per_q   <= on_per;
          cnt_q   <= cnt_first;
          tgt_q   <= S_ON_PH;
          state_q <= S_TOG;
          if (burst_mode) begin
            burst_q <= burst_q - 4'd1;
          end
        end
      end else begin
        // Static levels (OFF, ON, idle BURST): steer the shadow to the target.
        cnt_q <= '0;
        if (led_q != want_lit) begin
          tgt_q   <= want_lit ? S_ON_PH : S_OFF;
          state_q <= S_TOG;
        end else if (start_ok) begin
          busy_q  <= 1'b1;
          burst_q <= i_burst_n;
          per_q   <= on_per;
          cnt_q   <= cnt_first;
          tgt_q   <= S_ON_PH;
          state_q <= S_TOG;
        end else begin
          state_q <= want_lit ? S_ON_PH : S_OFF;
        end
      end
    end
  end

  assign o_enable_colorled = en_q;
  assign o_syncing_colLED  = sync_q;
  assign o_led_on          = led_q;
  assign o_busy            = busy_q;

endmodule

// File: tb/tb_colorled_blink_ctrl.sv
// Directed self-checking bench for colorled_blink_ctrl at TICK_DIV = 10.
module tb_colorled_blink_ctrl;
  import colorled_pkg::*;

  localparam int unsigned CLK_HZ  = 10_000;
  localparam int unsigned TICK_HZ = 1000;
  localparam int          CNT_W   = 16;

  logic             clk = 1'b0;
  logic             aresetn = 1'b0;
  logic [1:0]       i_mode = MODE_OFF;
  logic [CNT_W-1:0] i_on_ms = '0;
  logic [CNT_W-1:0] i_off_ms = '0;
  logic [3:0]       i_burst_n = 4'd0;
  logic             i_start = 1'b0;
  logic             o_enable_colorled;
  logic             o_syncing_colLED;
  logic             o_led_on;
  logic             o_busy;

  colorled_blink_ctrl #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ),
    .CNT_W  (CNT_W)
  ) dut (
    .clk              (clk),
    .aresetn          (aresetn),
    .i_mode           (i_mode),
    .i_on_ms          (i_on_ms),
    .i_off_ms         (i_off_ms),
    .i_burst_n        (i_burst_n),
    .i_start          (i_start),
    .o_enable_colorled(o_enable_colorled),
    .o_syncing_colLED (o_syncing_colLED),
    .o_led_on         (o_led_on),
    .o_busy           (o_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor: counts enable pulses and LED edges, stamps edges with
  // the cycle count and flags any edge not framed by a proper primitive.
  int led_edges = 0;
  int en_pulses = 0;
  int prim_errs = 0;
  int edge_cyc[$];
  bit edge_val[$];
  bit prev_en = 1'b0, prev_sync = 1'b0, prev_led = 1'b0, chk_sync_low = 1'b0;

  always @(negedge clk) begin
    if (aresetn) begin
      if (o_enable_colorled && !prev_en) en_pulses++;
      if (chk_sync_low && o_syncing_colLED) prim_errs++;
      chk_sync_low = 1'b0;
      if (o_led_on != prev_led) begin
        led_edges++;
        edge_cyc.push_back(cyc);
        edge_val.push_back(o_led_on);
        if (!(prev_en && prev_sync && !o_enable_colorled && o_syncing_colLED)) prim_errs++;
        chk_sync_low = 1'b1;
      end
      if (o_enable_colorled && !o_syncing_colLED) prim_errs++;
    end else begin
      chk_sync_low = 1'b0;
    end
    prev_en   = o_enable_colorled;
    prev_sync = o_syncing_colLED;
    prev_led  = o_led_on;
  end

  task automatic sync_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_edges(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (edge_cyc.size() >= target) break;
      sync_neg();
    end
    ok = (edge_cyc.size() >= target);
  endtask

  task automatic settle_off();
    i_mode = MODE_OFF;
    repeat (20) sync_neg();
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    i_mode  = MODE_OFF;
    repeat (5) sync_neg();
    n_checks++;
    if ({o_enable_colorled, o_syncing_colLED, o_led_on, o_busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_hold: outputs=%b expected 0000",
               {o_enable_colorled, o_syncing_colLED, o_led_on, o_busy});
    end
    aresetn = 1'b1;
    for (int i = 0; i < 100; i++) begin
      sync_neg();
      n_checks++;
      if ({o_enable_colorled, o_syncing_colLED, o_led_on, o_busy} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: outputs=%b expected 0000", i,
                 {o_enable_colorled, o_syncing_colLED, o_led_on, o_busy});
      end
    end
  endtask

  task automatic test_on_off();
    int p0, e0;
    p0 = en_pulses;
    e0 = led_edges;
    i_mode = MODE_ON;
    sync_neg();
    n_checks++;
    if (o_enable_colorled !== 1'b0) begin
      n_fail++;
      $display("FAIL on_latency_early: enable=%b expected 0", o_enable_colorled);
    end
    sync_neg();
    n_checks++;
    if ({o_enable_colorled, o_syncing_colLED} !== 2'b11) begin
      n_fail++;
      $display("FAIL on_latency: enable,sync=%b expected 11", {o_enable_colorled, o_syncing_colLED});
    end
    repeat (5) sync_neg();
    n_checks++;
    if (o_led_on !== 1'b1) begin
      n_fail++;
      $display("FAIL on_led: led=%b expected 1", o_led_on);
    end
    n_checks++;
    if (en_pulses - p0 != 1) begin
      n_fail++;
      $display("FAIL on_pulses: got %0d expected 1", en_pulses - p0);
    end
    i_mode = MODE_OFF;
    sync_neg();
    sync_neg();
    n_checks++;
    if ({o_enable_colorled, o_syncing_colLED} !== 2'b11) begin
      n_fail++;
      $display("FAIL off_latency: enable,sync=%b expected 11", {o_enable_colorled, o_syncing_colLED});
    end
    repeat (200) sync_neg();
    n_checks++;
    if (o_led_on !== 1'b0) begin
      n_fail++;
      $display("FAIL off_led: led=%b expected 0", o_led_on);
    end
    n_checks++;
    if (en_pulses - p0 != 2 || led_edges - e0 != 2) begin
      n_fail++;
      $display("FAIL on_off_count: pulses=%0d edges=%0d expected 2 and 2",
               en_pulses - p0, led_edges - e0);
    end
  endtask

  task automatic test_blink();
    int base, got, exp;
    bit ok;
    i_on_ms  = 16'd3;
    i_off_ms = 16'd2;
    base     = edge_cyc.size();
    i_mode   = MODE_BLINK;
    wait_edges(base + 12, 800, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL blink_timeout: edges=%0d expected 12", edge_cyc.size() - base);
    end else begin
      n_checks++;
      if (edge_val[base] !== 1'b1) begin
        n_fail++;
        $display("FAIL blink_first_edge: led=%b expected 1", edge_val[base]);
      end
      for (int i = 1; i <= 10; i++) begin
        exp = (i % 2 == 1) ? 20 : 30;
        got = edge_cyc[base + i + 1] - edge_cyc[base + i];
        n_checks++;
        if (got != exp) begin
          n_fail++;
          $display("FAIL blink_interval %0d: got %0d clocks expected %0d", i, got, exp);
        end
      end
    end
    settle_off();
  endtask

  task automatic test_zero_period();
    int base, got;
    bit ok;
    i_on_ms  = 16'd0;
    i_off_ms = 16'd0;
    base     = edge_cyc.size();
    i_mode   = MODE_BLINK;
    wait_edges(base + 7, 300, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL zero_timeout: edges=%0d expected 7", edge_cyc.size() - base);
    end else begin
      for (int i = 1; i <= 5; i++) begin
        got = edge_cyc[base + i + 1] - edge_cyc[base + i];
        n_checks++;
        if (got != 10) begin
          n_fail++;
          $display("FAIL zero_interval %0d: got %0d clocks expected 10", i, got);
        end
      end
    end
    settle_off();
  endtask

  task automatic test_burst();
    int e0, base, drop_edges, drop_cyc;
    bit ok;
    i_on_ms   = 16'd1;
    i_off_ms  = 16'd1;
    i_burst_n = 4'd0;
    i_mode    = MODE_BURST;
    repeat (5) sync_neg();
    e0 = led_edges;
    i_start = 1'b1;
    sync_neg();
    i_start = 1'b0;
    repeat (30) sync_neg();
    n_checks++;
    if (o_busy !== 1'b0 || led_edges != e0) begin
      n_fail++;
      $display("FAIL burst_n0_ignored: busy=%b edges=%0d expected 0 and 0", o_busy, led_edges - e0);
    end

    i_burst_n = 4'd3;
    e0   = led_edges;
    base = edge_cyc.size();
    i_start = 1'b1;
    sync_neg();
    i_start = 1'b0;
    n_checks++;
    if (o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL burst_busy_start: busy=%b expected 1", o_busy);
    end
    wait_edges(base + 2, 100, ok);
    i_start = 1'b1;
    sync_neg();
    i_start = 1'b0;
    drop_edges = -1;
    drop_cyc   = 0;
    for (int i = 0; i < 300; i++) begin
      if (!o_busy) begin
        drop_edges = led_edges - e0;
        drop_cyc   = cyc;
        break;
      end
      sync_neg();
    end
    n_checks++;
    if (drop_edges != 6) begin
      n_fail++;
      $display("FAIL burst_toggles_at_idle: got %0d expected 6", drop_edges);
    end
    n_checks++;
    if (o_led_on !== 1'b0) begin
      n_fail++;
      $display("FAIL burst_led_end: led=%b expected 0", o_led_on);
    end
    if (edge_cyc.size() >= base + 6) begin
      n_checks++;
      if (drop_cyc - edge_cyc[base + 5] != 8) begin
        n_fail++;
        $display("FAIL burst_final_off_phase: busy low %0d clocks after last edge expected 8",
                 drop_cyc - edge_cyc[base + 5]);
      end
    end
    repeat (100) sync_neg();
    n_checks++;
    if (led_edges - e0 != 6 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL burst_quiet_after: edges=%0d busy=%b expected 6 and 0", led_edges - e0, o_busy);
    end
  endtask

  task automatic test_abort();
    int base;
    bit ok;
    base = edge_cyc.size();
    i_start = 1'b1;
    sync_neg();
    i_start = 1'b0;
    wait_edges(base + 1, 100, ok);
    sync_neg();
    n_checks++;
    if (!ok || o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_precondition: lit=%b busy=%b expected 1 and 1", ok, o_busy);
    end
    i_mode = MODE_OFF;
    sync_neg();
    n_checks++;
    if (o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_busy: busy=%b expected 0", o_busy);
    end
    repeat (20) sync_neg();
    n_checks++;
    if (o_led_on !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_led: led=%b expected 0", o_led_on);
    end
  endtask

  task automatic test_reset_mid_toggle();
    bit seen;
    seen   = 1'b0;
    i_mode = MODE_ON;
    for (int i = 0; i < 10; i++) begin
      sync_neg();
      if (o_enable_colorled) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL midtog_enable: enable never rose within 10 clocks expected 1");
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({o_enable_colorled, o_syncing_colLED, o_led_on} !== 3'b011) begin
      n_fail++;
      $display("FAIL midtog_tplus1: enable,sync,led=%b expected 011",
               {o_enable_colorled, o_syncing_colLED, o_led_on});
    end
    aresetn = 1'b0;
    i_mode  = MODE_OFF;
    #1;
    n_checks++;
    if ({o_enable_colorled, o_syncing_colLED, o_led_on, o_busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL midtog_async_reset: outputs=%b expected 0000",
               {o_enable_colorled, o_syncing_colLED, o_led_on, o_busy});
    end
    repeat (3) sync_neg();
    aresetn = 1'b1;
    repeat (20) sync_neg();
    n_checks++;
    if ({o_enable_colorled, o_syncing_colLED, o_led_on, o_busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL midtog_after_release: outputs=%b expected 0000",
               {o_enable_colorled, o_syncing_colLED, o_led_on, o_busy});
    end
  endtask

  task automatic test_primitive_shape();
    n_checks++;
    if (prim_errs != 0) begin
      n_fail++;
      $display("FAIL primitive_shape: %0d malformed toggles expected 0", prim_errs);
    end
  endtask

  initial begin
    test_reset();
    test_on_off();
    test_blink();
    test_zero_period();
    test_burst();
    test_abort();
    test_primitive_shape();
    test_reset_mid_toggle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
